// File: rtl/imsic_protocol_pkg.sv
// Shared types and defaults for the IMSIC MSI delivery path.
// Holds the MSI arbiter FSM encoding and its default retry budget.
package imsic_protocol_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2
    } msi_arb_state_e;

    localparam int unsigned MSI_MAX_RETRIES = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above ptr, with wrap.
// ptr must be below N; the search wraps from N-1 back to 0 for any N.
module rr_arbiter #(
    parameter  int unsigned N    = 4,
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [IdxW-1:0] ptr,
    output logic [N-1:0]    gnt_onehot,
    output logic [IdxW-1:0] gnt_idx,
    output logic            any
);

    logic [IdxW:0]   sum;
    logic [IdxW-1:0] cand;

    // NOTE: every output and temporary gets a default before the loop so no path leaves a value held, which would infer a latch.
    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        any        = 1'b0;
        sum        = '0;
        cand       = '0;
        for (int i = 0; i < int'(N); i++) begin
            sum = {1'b0, ptr} + (IdxW+1)'(i);
            if (sum >= (IdxW+1)'(N)) begin
                sum = sum - (IdxW+1)'(N);
            end
            cand = sum[IdxW-1:0];
            if (!any && req[cand]) begin
                any              = 1'b1;
                gnt_idx          = cand;
                gnt_onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/imsic_msi_arbiter.sv
// Shares the single AXI-lite MSI write channel into the IMSIC between NrReq requesters.
// Round-robin grant, one write in flight, bounded retry on error responses.
module imsic_msi_arbiter
    import imsic_protocol_pkg::*;
#(
    parameter int unsigned NrReq      = 4,
    parameter int unsigned AddrWidth  = 32,
    parameter int unsigned DataWidth  = 32,
    parameter int unsigned MaxRetries = MSI_MAX_RETRIES
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [NrReq-1:0]           i_req_valid,
    input  logic [NrReq*AddrWidth-1:0] i_req_addr,
    input  logic [NrReq*DataWidth-1:0] i_req_data,
    output logic [NrReq-1:0]           o_req_ready,
    output logic [NrReq-1:0]           o_req_done,
    output logic [NrReq-1:0]           o_req_err,
    output logic                       o_wr_valid,
    output logic [AddrWidth-1:0]       o_wr_addr,
    output logic [DataWidth-1:0]       o_wr_data,
    input  logic                       i_wr_ready,
    input  logic                       i_wr_resp_valid,
    input  logic                       i_wr_resp_err,
    output logic                       o_busy,
    output logic [$clog2(NrReq)-1:0]   o_grant_idx
);

    localparam int unsigned IdxW   = $clog2(NrReq);
    localparam int unsigned RetryW = (MaxRetries > 0) ? $clog2(MaxRetries + 1) : 1;

    msi_arb_state_e      state_q;
    logic [IdxW-1:0]     rr_ptr_q;
    logic [IdxW-1:0]     grant_idx_q;
    logic [RetryW-1:0]   retry_cnt_q;
    logic [AddrWidth-1:0] addr_q;
    logic [DataWidth-1:0] data_q;
    logic [NrReq-1:0]    done_q;
    logic [NrReq-1:0]    err_q;

    logic [AddrWidth-1:0] req_addr_arr [NrReq];
    logic [DataWidth-1:0] req_data_arr [NrReq];

    for (genvar g = 0; g < int'(NrReq); g++) begin : g_unpack
        assign req_addr_arr[g] = i_req_addr[g*AddrWidth +: AddrWidth];
        assign req_data_arr[g] = i_req_data[g*DataWidth +: DataWidth];
    end

    logic [NrReq-1:0] arb_onehot;
    logic [IdxW-1:0]  arb_idx;
    logic             arb_any;

    rr_arbiter #(.N(NrReq)) u_rr_arbiter (
        .req        (i_req_valid),
        .ptr        (rr_ptr_q),
        .gnt_onehot (arb_onehot),
        .gnt_idx    (arb_idx),
        .any        (arb_any)
    );

    // NOTE: ready is combinational so the requester sees its accept in the same cycle it is latched; it is masked during reset because the FSM does not take the grant then.
    assign o_req_ready = (state_q == IDLE && !i_rst) ? arb_onehot : '0;
    assign o_wr_valid  = (state_q == ISSUE);
    assign o_busy      = (state_q != IDLE);
    assign o_wr_addr   = addr_q;
    assign o_wr_data   = data_q;
    assign o_grant_idx = grant_idx_q;
    assign o_req_done  = done_q;
    assign o_req_err   = err_q;

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_idx_q <= '0;
            retry_cnt_q <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            done_q      <= '0;
            err_q       <= '0;
        end else begin
            done_q <= '0;
            err_q  <= '0;
            case (state_q)
                IDLE: begin
                    if (arb_any) begin
                        addr_q      <= req_addr_arr[arb_idx];
                        data_q      <= req_data_arr[arb_idx];
                        grant_idx_q <= arb_idx;
                        retry_cnt_q <= '0;
                        rr_ptr_q    <= (arb_idx == IdxW'(NrReq - 1)) ? '0 : arb_idx + 1'b1;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (i_wr_ready) begin
                        state_q <= WAIT_RESP;
                    end
                end
                WAIT_RESP: begin
                    if (i_wr_resp_valid) begin
                        if (i_wr_resp_err && (retry_cnt_q < RetryW'(MaxRetries))) begin
                            retry_cnt_q <= retry_cnt_q + 1'b1;
                            state_q     <= ISSUE;
                        end else begin
                            done_q[grant_idx_q] <= 1'b1;
                            err_q[grant_idx_q]  <= i_wr_resp_err;
                            state_q             <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imsic_msi_arbiter.sv
// Directed bench for imsic_msi_arbiter: inputs change on the falling edge, outputs are checked 1ns later.
module tb_imsic_msi_arbiter;

    localparam int NR = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic [NR-1:0]     i_req_valid;
    logic [NR*AW-1:0]  i_req_addr;
    logic [NR*DW-1:0]  i_req_data;
    logic [NR-1:0]     o_req_ready;
    logic [NR-1:0]     o_req_done;
    logic [NR-1:0]     o_req_err;
    logic              o_wr_valid;
    logic [AW-1:0]     o_wr_addr;
    logic [DW-1:0]     o_wr_data;
    logic              i_wr_ready;
    logic              i_wr_resp_valid;
    logic              i_wr_resp_err;
    logic              o_busy;
    logic [1:0]        o_grant_idx;

    int checks   = 0;
    int failures = 0;

    imsic_msi_arbiter #(
        .NrReq(NR), .AddrWidth(AW), .DataWidth(DW), .MaxRetries(2)
    ) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_req_valid     (i_req_valid),
        .i_req_addr      (i_req_addr),
        .i_req_data      (i_req_data),
        .o_req_ready     (o_req_ready),
        .o_req_done      (o_req_done),
        .o_req_err       (o_req_err),
        .o_wr_valid      (o_wr_valid),
        .o_wr_addr       (o_wr_addr),
        .o_wr_data       (o_wr_data),
        .i_wr_ready      (i_wr_ready),
        .i_wr_resp_valid (i_wr_resp_valid),
        .i_wr_resp_err   (i_wr_resp_err),
        .o_busy          (o_busy),
        .o_grant_idx     (o_grant_idx)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge i_clk);
    endtask

    task automatic set_req(input int idx, input logic [AW-1:0] a, input logic [DW-1:0] d);
        i_req_addr[idx*AW +: AW] = a;
        i_req_data[idx*DW +: DW] = d;
    endtask

    task automatic do_reset();
        cyc();
        i_rst = 1'b1;
        cyc();
        cyc();
        i_rst = 1'b0;
    endtask

    // Called 1ns into a cycle where ISSUE is expected; returns 1ns into the cycle after the response.
    task automatic issue_resp(input string tag, input logic err, input logic [AW-1:0] ea, input logic [DW-1:0] ed);
        check({tag, "_wr_valid"}, o_wr_valid, 1);
        check({tag, "_addr"}, o_wr_addr, ea);
        check({tag, "_data"}, o_wr_data, ed);
        i_wr_ready = 1'b1;
        cyc();
        i_wr_ready      = 1'b0;
        i_wr_resp_valid = 1'b1;
        i_wr_resp_err   = err;
        #1;
        check({tag, "_wait_valid"}, o_wr_valid, 0);
        cyc();
        i_wr_resp_valid = 1'b0;
        i_wr_resp_err   = 1'b0;
        #1;
    endtask

    int order[$];
    int grant_cnt[NR];
    int done_cnt[NR];
    logic stable;

    task automatic tally();
        for (int i = 0; i < NR; i++) begin
            if (o_req_ready[i]) begin
                order.push_back(i);
                grant_cnt[i]++;
            end
            if (o_req_done[i]) done_cnt[i]++;
        end
    endtask

    initial begin
        i_rst = 1'b1;
        i_req_valid = '0;
        i_req_addr = '0;
        i_req_data = '0;
        i_wr_ready = 1'b0;
        i_wr_resp_valid = 1'b0;
        i_wr_resp_err = 1'b0;
        cyc();
        cyc();
        cyc();
        i_rst = 1'b0;
        #1;
        check("rst_busy", o_busy, 0);
        check("rst_wr_valid", o_wr_valid, 0);
        check("rst_addr", o_wr_addr, 0);
        check("rst_grant", o_grant_idx, 0);
        check("rst_done", o_req_done, 0);

        // Single requester 1, ok response four cycles after the grant.
        cyc(); set_req(1, 32'h2800_1000, 32'h5); i_req_valid = 4'b0010; #1;
        check("t1_ready", o_req_ready, 4'b0010);
        cyc(); i_req_valid = '0; i_wr_ready = 1'b1; #1;
        check("t1_wr_valid", o_wr_valid, 1);
        check("t1_addr", o_wr_addr, 32'h2800_1000);
        check("t1_data", o_wr_data, 32'h5);
        check("t1_grant", o_grant_idx, 1);
        cyc(); i_wr_ready = 1'b0; #1;
        check("t1_valid_drop", o_wr_valid, 0);
        check("t1_busy_wait", o_busy, 1);
        cyc();
        cyc(); i_wr_resp_valid = 1'b1; #1;
        check("t1_no_early_done", o_req_done, 0);
        cyc(); i_wr_resp_valid = 1'b0; #1;
        check("t1_done", o_req_done, 4'b0010);
        check("t1_err", o_req_err, 0);
        check("t1_idle", o_busy, 0);
        cyc(); #1;
        check("t1_done_pulse", o_req_done, 0);

        // All four valid continuously against a zero-latency master and response.
        do_reset();
        for (int i = 0; i < NR; i++) set_req(i, 32'h2800_0000 + 32'(i * 'h100), 32'(i + 16));
        i_req_valid = 4'hF; i_wr_ready = 1'b1; i_wr_resp_valid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            #1;
            tally();
            if (order.size() >= 5) break;
            cyc();
        end
        cyc(); i_req_valid = '0;
        for (int c = 0; c < 8; c++) begin
            #1;
            tally();
            cyc();
        end
        i_wr_ready = 1'b0; i_wr_resp_valid = 1'b0;
        check("t2_grants", order.size(), 5);
        for (int k = 0; k < 5; k++) check($sformatf("t2_order%0d", k), (order.size() > k) ? order[k] : -1, k % NR);
        check("t2_done0", done_cnt[0], 2);
        for (int i = 1; i < NR; i++) check($sformatf("t2_done%0d", i), done_cnt[i], 1);

        // Requester 2 with the master stalling ten cycles; a stray response in ISSUE is ignored.
        cyc(); set_req(2, 32'h2800_2000, 32'h2A); i_req_valid = 4'b0100; #1;
        check("t3_ready", o_req_ready, 4'b0100);
        stable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            cyc(); i_req_valid = '0; i_wr_resp_valid = (c == 3); #1;
            if (!(o_wr_valid && o_wr_addr == 32'h2800_2000 && o_wr_data == 32'h2A && o_req_done == '0))
                stable = 1'b0;
        end
        check("t3_stable", stable, 1);
        cyc(); i_wr_resp_valid = 1'b0; i_wr_ready = 1'b1; #1;
        check("t3_still_issue", o_wr_valid, 1);
        cyc(); i_wr_ready = 1'b0; #1;
        check("t3_wait_valid", o_wr_valid, 0);
        check("t3_wait_busy", o_busy, 1);
        cyc(); i_wr_resp_valid = 1'b1; #1;
        cyc(); i_wr_resp_valid = 1'b0; #1;
        check("t3_done", o_req_done, 4'b0100);
        check("t3_err", o_req_err, 0);

        // Three error responses exhaust MaxRetries=2.
        cyc(); set_req(2, 32'h2800_2004, 32'h7); i_req_valid = 4'b0100; #1;
        check("t4a_ready", o_req_ready, 4'b0100);
        cyc(); i_req_valid = '0; #1;
        issue_resp("t4a_1", 1'b1, 32'h2800_2004, 32'h7);
        issue_resp("t4a_2", 1'b1, 32'h2800_2004, 32'h7);
        issue_resp("t4a_3", 1'b1, 32'h2800_2004, 32'h7);
        check("t4a_done", o_req_done, 4'b0100);
        check("t4a_err", o_req_err, 4'b0100);
        check("t4a_no_4th", o_wr_valid, 0);
        cyc(); #1;
        check("t4a_done_pulse", o_req_done, 0);

        // Error then ok: one retry, clean completion.
        cyc(); set_req(2, 32'h2800_2008, 32'h9); i_req_valid = 4'b0100; #1;
        check("t4b_ready", o_req_ready, 4'b0100);
        cyc(); i_req_valid = '0; #1;
        issue_resp("t4b_1", 1'b1, 32'h2800_2008, 32'h9);
        issue_resp("t4b_2", 1'b0, 32'h2800_2008, 32'h9);
        check("t4b_done", o_req_done, 4'b0100);
        check("t4b_err", o_req_err, 0);

        // Reset in WAIT_RESP abandons the write; rr_ptr is 2 before the reset.
        cyc(); set_req(1, 32'h2800_1010, 32'h11); i_req_valid = 4'b0010; #1;
        check("t5_ready", o_req_ready, 4'b0010);
        cyc(); i_req_valid = '0; i_wr_ready = 1'b1; #1;
        cyc(); i_wr_ready = 1'b0; i_rst = 1'b1; #1;
        cyc(); i_rst = 1'b0; #1;
        check("t5_busy", o_busy, 0);
        check("t5_wr_valid", o_wr_valid, 0);
        check("t5_addr", o_wr_addr, 0);
        check("t5_data", o_wr_data, 0);
        check("t5_grant", o_grant_idx, 0);
        check("t5_done", o_req_done, 0);
        cyc(); i_wr_resp_valid = 1'b1; i_wr_resp_err = 1'b1; #1;
        cyc(); i_wr_resp_valid = 1'b0; i_wr_resp_err = 1'b0; #1;
        check("t6_spurious_done", o_req_done, 0);
        check("t6_spurious_err", o_req_err, 0);
        check("t6_spurious_busy", o_busy, 0);
        cyc(); set_req(0, 32'h2800_0040, 32'h1); set_req(3, 32'h2800_3000, 32'h3); i_req_valid = 4'b1001; #1;
        check("t5_rr_from0", o_req_ready, 4'b0001);
        cyc(); i_req_valid = '0; #1;
        check("t5_grant0", o_grant_idx, 0);
        issue_resp("t5_issue", 1'b0, 32'h2800_0040, 32'h1);
        check("t5_done0", o_req_done, 4'b0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imsic_msi_arbiter.md
Name: imsic_msi_arbiter

Overview:
- Shares one AXI-lite MSI write channel, the one feeding the IMSIC island, between NrReq MSI requesters (APLIC domains, test injectors).
- Grants requesters round-robin and holds one write in flight at a time.
- Drives the write-master handshake and waits for the write response.
- Retries errored writes up to MaxRetries, then reports done/error per requester.

Parameters:
- NrReq, 4, number of MSI requesters (≥2).
- AddrWidth, 32, MSI address width (matches ProtocolCfg.AXI_ADDR_WIDTH).
- DataWidth, 32, MSI data width (matches ProtocolCfg.AXI_DATA_WIDTH).
- MaxRetries, 2, extra attempts after an error response (0 = no retry).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset; synchronous, active-high.
- i_req_valid  in  NrReq  per-requester MSI pending; held until accepted.
- i_req_addr  in  NrReq*AddrWidth  packed per-requester MSI address.
- i_req_data  in  NrReq*DataWidth  packed per-requester MSI data (EIID).
- o_req_ready  out  NrReq  one-hot accept pulse.
- o_req_done  out  NrReq  one-hot completion pulse.
- o_req_err  out  NrReq  one-hot error pulse; only asserted together with o_req_done.
- o_wr_valid  out  1  write request to the AXI-lite write master.
- o_wr_addr  out  AddrWidth  latched address.
- o_wr_data  out  DataWidth  latched data.
- i_wr_ready  in  1  master accepts the write this cycle.
- i_wr_resp_valid  in  1  write response (B) received.
- i_wr_resp_err  in  1  response is SLVERR/DECERR; valid with i_wr_resp_valid.
- o_busy  out  1  FSM not IDLE.
- o_grant_idx  out  $clog2(NrReq)  index of the current owner.

Behaviour:
- Reset, sampled at the i_clk edge while i_rst=1:
  - FSM=IDLE, rr_ptr=0, retry_cnt=0.
  - All outputs 0: o_wr_addr/o_wr_data=0, o_grant_idx=0.
  - An in-flight write is abandoned; no done/err pulse is issued for it.
- IDLE:
  - If any i_req_valid, pick the first valid index searching from rr_ptr upward with wrap.
  - o_req_ready[idx]=1 combinationally in this cycle.
  - Latch addr/data/idx, set retry_cnt=0, rr_ptr=(idx+1) mod NrReq, go to ISSUE.
  - If none valid, stay in IDLE.
- ISSUE:
  - o_wr_valid=1; o_wr_addr/o_wr_data stay stable until i_wr_ready.
  - On i_wr_ready go to WAIT_RESP; o_wr_valid drops the next cycle.
- WAIT_RESP: on i_wr_resp_valid:
  - If err and retry_cnt<MaxRetries: retry_cnt+=1, go to ISSUE with the same addr/data.
  - Otherwise go to IDLE. Next cycle: o_req_done[idx]=1, and o_req_err[idx]=i_wr_resp_err as registered (one-cycle pulses).
- A response arriving in IDLE or ISSUE is ignored.
- Latency:
  - Valid in an IDLE cycle T → ready at T, o_wr_valid at T+1.
  - Response at cycle R → done at R+1.
  - IDLE may grant again at R+1, so the done pulse and the next grant can coincide.
- Fairness:
  - A requester re-asserting valid right after being served waits behind all other pending requesters.
  - rr_ptr advances only on a grant.
- Requester dropping valid before grant: allowed, nothing is latched. Valid in the same cycle as its own done: treated as a new request.
- A single requester (all others idle) is served back-to-back; rr_ptr wraps to it.
- retry_cnt width is $clog2(MaxRetries+1); it never wraps because it is bounded by the compare.
- o_busy=1 in ISSUE and WAIT_RESP.
- o_grant_idx holds the last granted index in IDLE.
- NrReq not a power of two: rr_ptr wraps from NrReq-1 to 0.

Decomposition:
- In imsic_protocol_pkg: msi_arb_state_e {IDLE, ISSUE, WAIT_RESP}, and the default MaxRetries constant.
- Sub-module rr_arbiter (parameter N): inputs req[N], ptr; outputs gnt_onehot, gnt_idx, any. Purely combinational, instantiated once.
- FSM, latches and counters live in the top.

Test Plan:
- Only req1 valid (addr 0x2800_1000, data 0x5) → ready[1] at T; wr_valid T+1 with 0x2800_1000/0x5; resp ok at T+4 → done[1] at T+5, err[1]=0.
- All four valid continuously, zero-latency master/resp → grant order 0,1,2,3,0; each gets exactly one done per grant; no index granted twice in a row.
- req2 with i_wr_ready held low 10 cycles → o_wr_valid and addr/data stable all 10 cycles; WAIT_RESP entered only after ready.
- MaxRetries=2, resp err three times → wr_valid issued three times with identical addr/data, then done[2]=err[2]=1; with an err-ok sequence → two issues, done[2]=1, err[2]=0.
- i_rst=1 during WAIT_RESP → next cycle all outputs 0, FSM IDLE, no done pulse; a response arriving after reset is ignored; the next grant starts from index 0.
- Spurious i_wr_resp_valid in IDLE → no done/err pulse, no state change.
